// File: rtl/ni_flit_packetizer.sv
// ni_flit_packetizer: network-interface transmitter for a router local port.
// Takes a packet descriptor plus a stream of 28-bit payload words. It emits one
// header flit, (len-2) body flits and one tail flit. Flits go out one per cycle
// while the router FIFO reports space (tx_cts).
// Optional feature: define PARITY_EN to place even parity of flit[31:1] in bit 0.
// Without PARITY_EN, bit 0 of every flit is driven 0.
module ni_flit_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int LEN_W      = 12,
  parameter int PID_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXIS-1:0]       cur_addr,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [AXIS-1:0]       pkt_dst,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [27:0]           pl_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_drts,
  input  logic                  tx_cts,
  output logic                  busy,
  output logic                  pkt_sent,
  output logic                  len_err
);

  localparam logic [2:0] TYPE_HDR  = 3'b001;
  localparam logic [2:0] TYPE_BODY = 3'b010;
  localparam logic [2:0] TYPE_TAIL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hdr_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [PID_W-1:0]        pid_q;

  logic                    accept;
  logic                    short_len;
  logic [LEN_W-1:0]        eff_len;
  logic                    pending;
  logic                    last_body;
  logic [DATA_WIDTH-1:0]   flit;

  // Fill in bit 0 of an outgoing flit: even parity over [31:1], or a constant 0.
  function automatic logic [DATA_WIDTH-1:0] with_parity(input logic [DATA_WIDTH-1:0] f);
`ifdef PARITY_EN
    return {f[DATA_WIDTH-1:1], ^f[DATA_WIDTH-1:1]};
`else
    return {f[DATA_WIDTH-1:1], 1'b0};
`endif
  endfunction

  // Lengths below 2 cannot hold a header and a tail, so they are promoted to 2.
  assign short_len = (pkt_len < LEN_W'(2));
  assign eff_len   = short_len ? LEN_W'(2) : pkt_len;
  assign last_body = (cnt_q == (len_q - LEN_W'(3)));

  // Next-state logic plus the flit/handshake outputs, decoded from the current state.
  always_comb begin
    state_d   = state_q;
    flit      = '0;
    pending   = 1'b0;
    pl_ready  = 1'b0;
    pkt_ready = 1'b0;
    accept    = 1'b0;
    len_err   = 1'b0;
    pkt_sent  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so that every output reads 0 while reset is held.
        pkt_ready = !rst;
        accept    = pkt_valid && !rst;
        len_err   = accept && short_len;
        if (accept) state_d = HDR;
      end
      HDR: begin
        flit    = hdr_q;
        pending = 1'b1;
        if (tx_cts) state_d = (len_q > LEN_W'(2)) ? BODY : TAIL;
      end
      BODY: begin
        flit     = {TYPE_BODY, pl_data, 1'b0};
        pending  = pl_valid;
        pl_ready = tx_cts;
        if (pl_valid && tx_cts && last_body) state_d = TAIL;
      end
      TAIL: begin
        flit     = {TYPE_TAIL, pl_data, 1'b0};
        pending  = pl_valid;
        pl_ready = tx_cts;
        if (pl_valid && tx_cts) begin
          pkt_sent = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The strobe follows tx_cts combinationally, so a flit is held, never dropped.
  assign tx_drts = pending && tx_cts;
  assign tx_data = pending ? with_parity(flit) : '0;
  assign busy    = (state_q != IDLE);

  // State, latched header, body counter and packet id.
  // An asynchronous reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q <= eff_len;
        cnt_q <= '0;
        hdr_q <= {TYPE_HDR, eff_len, pkt_dst, cur_addr, pid_q, 1'b0};
      end
      if ((state_q == BODY) && tx_drts) cnt_q <= last_body ? '0 : cnt_q + LEN_W'(1);
      if (pkt_sent) pid_q <= pid_q + PID_W'(1);
    end
  end

endmodule
